// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory response pipeline.
package mem_resp_pkg;

  localparam int unsigned BURST_LEN   = 4;
  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // One response beat travelling down the delay line.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } resp_beat_t;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-depth shift register that delays read responses; cleared synchronously by rst.
module resp_delay_line
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  resp_beat_t din,
  output resp_beat_t dout
);

  resp_beat_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mem_resp_pipe.sv
// Pipelined 16-bit word memory with fixed read latency.
// Define MEM_RESP_BURST_EN to enable 4-beat burst reads via req_burst.
module mem_resp_pipe
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY        = DEF_LATENCY,
  parameter int unsigned MEM_WORDS_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] resp_addr
);

  localparam int unsigned WORDS = 1 << MEM_WORDS_LOG2;

  logic [15:0] mem [WORDS];
  logic        ready_q;
  logic        accept_c;
  logic        rd_accept_c;
  logic        issue_valid_c;
  logic [15:0] issue_addr_c;
  logic        unused_c;
  resp_beat_t  issue_c;
  resp_beat_t  resp_q;

  assign accept_c    = req_valid & ready_q & ~rst;
  assign rd_accept_c = accept_c & ~req_wr;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_c && req_wr) mem[req_addr[MEM_WORDS_LOG2:1]] <= req_wdata;
  end

`ifdef MEM_RESP_BURST_EN
  burst_state_t state_q;
  logic [1:0]   beat_q;
  logic [12:0]  base_q;

  // Burst sequencer: beat 0 issues on acceptance, beats 1..3 on following cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      base_q  <= 13'd0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_accept_c && req_burst) begin
            state_q <= BURST;
            beat_q  <= 2'd1;
            base_q  <= req_addr[15:3];
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        BURST: begin
          beat_q <= 2'(beat_q + 2'd1);
          if (beat_q == 2'(BURST_LEN - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    issue_valid_c = rd_accept_c;
    issue_addr_c  = {req_addr[15:1], 1'b0};
    if (state_q == BURST) begin
      issue_valid_c = 1'b1;
      issue_addr_c  = {base_q, beat_q, 1'b0};
    end else if (rd_accept_c && req_burst) begin
      issue_addr_c = {req_addr[15:3], 3'b000};
    end
  end

  assign unused_c = req_addr[0];
`else
  always_ff @(posedge clk) begin
    ready_q <= ~rst;
  end

  always_comb begin
    issue_valid_c = rd_accept_c;
    issue_addr_c  = {req_addr[15:1], 1'b0};
  end

  assign unused_c = req_burst ^ req_addr[0];
`endif

  // Idle beats carry zeros so the outputs read 0 whenever resp_valid is low.
  always_comb begin
    issue_c = '0;
    if (issue_valid_c) begin
      issue_c.valid = 1'b1;
      issue_c.addr  = issue_addr_c;
      issue_c.data  = mem[issue_addr_c[MEM_WORDS_LOG2:1]];
    end
  end

  resp_delay_line #(
    .DEPTH(LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din (issue_c),
    .dout(resp_q)
  );

  assign req_ready  = ready_q;
  assign resp_valid = resp_q.valid;
  assign resp_rdata = resp_q.data;
  assign resp_addr  = resp_q.addr;

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Directed bench for mem_resp_pipe with a per-cycle reference model and literal pins.
module tb_mem_resp_pipe;

  localparam int unsigned L     = 4;
  localparam int unsigned LOG2  = 4;
  localparam int unsigned WORDS = 16;
  localparam int          NSLOT = 512;
`ifdef MEM_RESP_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] resp_addr;

  always #5 clk = ~clk;

  mem_resp_pipe #(
    .LATENCY(L),
    .MEM_WORDS_LOG2(LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_addr (resp_addr)
  );

  int cyc = -1;
  int passed = 0;
  int total = 0;

  // Reference model state: word store plus expected outputs indexed by cycle slot.
  logic [15:0] mmem [WORDS];
  bit          exp_v [NSLOT];
  logic [15:0] exp_d [NSLOT];
  logic [15:0] exp_a [NSLOT];
  bit          exp_r [NSLOT];
  logic        act_v [NSLOT];
  logic [15:0] act_d [NSLOT];
  logic [15:0] act_a [NSLOT];
  logic        act_r [NSLOT];
  bit          prev_ready = 1'b0;
  int          burst_left = 0;
  logic [15:0] burst_base = 16'h0;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void sched(int slot, logic [15:0] a);
    if (slot < NSLOT) begin
      exp_v[slot] = 1'b1;
      exp_a[slot] = a;
      exp_d[slot] = mmem[a[LOG2:1]];
    end
  endfunction

  // Model: a read issued at edge n is visible in slot n+L-1; reset wipes everything in flight.
  always @(posedge clk) begin
    int n;
    cyc++;
    n = cyc;
    if (n >= NSLOT) begin
      $display("FAIL cycle_budget: got %0d want <%0d", n, NSLOT);
      $fatal(1);
    end
    if (rst) begin
      for (int i = n; i < NSLOT; i++) exp_v[i] = 1'b0;
      burst_left = 0;
      exp_r[n] = 1'b0;
    end else begin
      if (burst_left > 0) begin
        sched(n + int'(L) - 1, burst_base + 16'(2 * (4 - burst_left)));
        burst_left--;
      end
      if (req_valid && prev_ready) begin
        if (req_wr) mmem[req_addr[LOG2:1]] = req_wdata;
        else if (BURST_ON && req_burst) begin
          burst_base = {req_addr[15:3], 3'b000};
          sched(n + int'(L) - 1, burst_base);
          burst_left = 3;
        end else sched(n + int'(L) - 1, {req_addr[15:1], 1'b0});
      end
      exp_r[n] = (burst_left == 0);
    end
    prev_ready = exp_r[n];
  end

  always @(negedge clk) begin
    if (cyc >= 0 && cyc < NSLOT) begin
      act_v[cyc] = resp_valid;
      act_d[cyc] = resp_rdata;
      act_a[cyc] = resp_addr;
      act_r[cyc] = req_ready;
      chk("resp_valid", 16'(resp_valid), 16'(exp_v[cyc]));
      chk("resp_rdata", resp_rdata, exp_v[cyc] ? exp_d[cyc] : 16'h0);
      chk("resp_addr", resp_addr, exp_v[cyc] ? exp_a[cyc] : 16'h0);
      chk("req_ready", 16'(req_ready), 16'(exp_r[cyc]));
    end
  end

  task automatic drive(input bit v, input bit wr, input bit bu,
                       input logic [15:0] a, input logic [15:0] d, output int slot);
    slot      = cyc;
    req_valid = v;
    req_wr    = wr;
    req_burst = bu;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    int s;
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, s);
  endtask

  // Pins both the model and the DUT to a hand-computed response.
  function automatic void pin(string name, int slot, logic [15:0] d, logic [15:0] a);
    chk({name, "_model_valid"}, 16'(exp_v[slot]), 16'h1);
    chk({name, "_model_data"}, exp_d[slot], d);
    chk({name, "_model_addr"}, exp_a[slot], a);
    chk({name, "_dut_valid"}, 16'(act_v[slot]), 16'h1);
    chk({name, "_dut_data"}, act_d[slot], d);
    chk({name, "_dut_addr"}, act_a[slot], a);
  endfunction

  int s, s_a, s_b, s_c1, s_c2, s_d1, s_d2, s_e, s_e2, s_f, s_f2;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1);

    drive(1, 1, 1, 16'h0010, 16'h1234, s);
    drive(1, 0, 0, 16'h0010, 16'h0, s_a);

    drive(1, 1, 0, 16'h0000, 16'h000A, s);
    drive(1, 1, 0, 16'h0002, 16'h000B, s);
    drive(1, 1, 0, 16'h0004, 16'h000C, s);
    drive(1, 0, 0, 16'h0000, 16'h0, s_b);
    drive(1, 0, 0, 16'h0002, 16'h0, s);
    drive(1, 0, 0, 16'h0004, 16'h0, s);

    drive(1, 1, 0, 16'h0020, 16'h1111, s);
    drive(1, 0, 0, 16'h0020, 16'h0, s_c1);
    drive(1, 1, 0, 16'h0020, 16'h2222, s);
    drive(1, 0, 0, 16'h0020, 16'h0, s_c2);

    drive(1, 0, 0, 16'h0021, 16'h0, s_d1);
    drive(1, 1, 0, 16'h0020, 16'h3333, s);
    drive(1, 0, 0, 16'h0000, 16'h0, s_d2);
    idle(6);

    drive(1, 0, 0, 16'h0010, 16'h0, s_e);
    idle(1);
    rst = 1'b1;
    drive(1, 1, 0, 16'h0010, 16'hBEEF, s);
    idle(1);
    rst = 1'b0;
    idle(3);
    drive(1, 0, 0, 16'h0010, 16'h0, s_e2);
    idle(2);

    if (BURST_ON) begin
      drive(1, 1, 0, 16'h0040, 16'h0001, s);
      drive(1, 1, 0, 16'h0042, 16'h0002, s);
      drive(1, 1, 0, 16'h0044, 16'h0003, s);
      drive(1, 1, 0, 16'h0046, 16'h0004, s);
      drive(1, 0, 1, 16'h0045, 16'h0, s_f);
      drive(1, 1, 0, 16'h0040, 16'hDEAD, s);
      idle(2);
      drive(1, 0, 0, 16'h0040, 16'h0, s_f2);
    end
    idle(10);

    chk("ready_in_reset", 16'(act_r[2]), 16'h0);
    chk("ready_after_reset", 16'(act_r[3]), 16'h1);
    pin("wr_then_rd", s_a + int'(L), 16'h1234, 16'h0010);
    pin("b2b_0", s_b + int'(L), 16'h000A, 16'h0000);
    pin("b2b_1", s_b + int'(L) + 1, 16'h000B, 16'h0002);
    pin("b2b_2", s_b + int'(L) + 2, 16'h000C, 16'h0004);
    pin("wr_behind_rd", s_c1 + int'(L), 16'h1111, 16'h0020);
    pin("rd_after_wr", s_c2 + int'(L), 16'h2222, 16'h0020);
    pin("odd_addr", s_d1 + int'(L), 16'h2222, 16'h0020);
    pin("wrap_alias", s_d2 + int'(L), 16'h3333, 16'h0000);
    for (int i = s_e; i <= s_e + 8; i++) begin
      chk("rst_flush_model", 16'(exp_v[i]), 16'h0);
      chk("rst_flush_dut", 16'(act_v[i]), 16'h0);
    end
    chk("ready_rst_held", 16'(act_r[s_e + 4]), 16'h0);
    chk("ready_after_rst_drop", 16'(act_r[s_e + 5]), 16'h1);
    pin("storage_kept", s_e2 + int'(L), 16'h1234, 16'h0010);
    if (BURST_ON) begin
      for (int i = 0; i < 4; i++)
        pin("burst_beat", s_f + int'(L) + i, 16'(i + 1), 16'(16'h0040 + 16'(2 * i)));
      for (int i = 1; i <= 3; i++) chk("burst_ready_low", 16'(act_r[s_f + i]), 16'h0);
      chk("burst_ready_back", 16'(act_r[s_f + 4]), 16'h1);
      pin("burst_ignored_wr", s_f2 + int'(L), 16'h0001, 16'h0040);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_resp_pipe.md
MEM_RESP_PIPE -- requirements
Module: mem_resp_pipe

Interface
REQ-001 Parameter: LATENCY, default 4, cycles from read acceptance to resp_valid (legal 1..8).
REQ-002 Parameter: MEM_WORDS_LOG2, default 15, log2 of storage depth in 16-bit words.
REQ-003 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: req_valid  in  1  request present.
REQ-007 Port: req_wr  in  1  1 = write, 0 = read.
REQ-008 Port: req_burst  in  1  burst-read request, used only under the macro in REQ-027.
REQ-009 Port: req_addr  in  16  byte address; bit 0 ignored.
REQ-010 Port: req_wdata  in  16  write data.
REQ-011 Port: req_ready  out  1  request can be accepted this cycle.
REQ-012 Port: resp_valid  out  1  read data valid this cycle.
REQ-013 Port: resp_rdata  out  16  read data.
REQ-014 Port: resp_addr  out  16  word-aligned address of resp_rdata.

Function
REQ-015 Acceptance: a request is accepted when req_valid & req_ready are high at the clk edge; otherwise it is ignored, with no side effect.
REQ-016 Word index: req_addr[MEM_WORDS_LOG2:1]; higher address bits are ignored, so addresses wrap modulo the depth.
REQ-017 Writes: an accepted write stores req_wdata at the acceptance edge and produces no response.
REQ-018 Reads: an accepted read samples storage at the acceptance edge. resp_valid then asserts exactly LATENCY cycles later for one cycle, with resp_rdata and resp_addr ({req_addr[15:1],1'b0}).
REQ-019 Throughput: fully pipelined, one accepted request per cycle. Responses return in acceptance order, and up to LATENCY reads are in flight.
REQ-020 Write then read: a write accepted on cycle N is visible to a read accepted on cycle N+1 or later.
REQ-021 Write behind a read: a write accepted after a read to the same word does not alter that read's in-flight data.
REQ-022 Idle outputs: when resp_valid=0, resp_rdata and resp_addr hold 16'h0000.
REQ-023 Ready without the macro: req_ready=1 in every non-reset cycle.

Reset
REQ-024 While rst=1: req_ready=0, resp_valid=0, resp_rdata=16'h0000, resp_addr=16'h0000, and all in-flight reads are discarded.
REQ-025 After reset: req_ready=1 on the first cycle after rst deasserts.
REQ-026 Storage: contents are not cleared by rst. A reset asserted mid-burst aborts the burst, and no further beats are issued.

Configuration
REQ-027 Macro MEM_RESP_BURST_EN defined: an accepted read with req_burst=1 returns 4 words at base {req_addr[15:3],3'b000} in order +0,+2,+4,+6.
- Beats appear on consecutive cycles, starting LATENCY cycles after acceptance.
- The burst is one state machine: IDLE -> BURST (counter 0..3) -> IDLE.
- req_ready=0 for the 3 cycles after a burst acceptance.
- Each beat samples storage on its own issue cycle.
- req_burst on a write is ignored.
REQ-028 Macro MEM_RESP_BURST_EN undefined: req_burst is ignored, every read is single-word, and the burst FSM and counter are absent.

Structure
REQ-029 Shared package mem_resp_pkg holds BURST_LEN=4, the default LATENCY constant, and the burst FSM state typedef {IDLE, BURST}.
REQ-030 Sub-module resp_delay_line: a LATENCY-deep shift register carrying {valid, addr[15:0], data[15:0]}, with synchronous clear on rst.

Verification
REQ-031 Write then read: write 0x1234 to 0x0010, then read 0x0010 the next cycle -> resp_valid 4 cycles after the read, resp_rdata=0x1234, resp_addr=0x0010.
REQ-032 Back-to-back reads: reads of 0x0000, 0x0002, 0x0004 on consecutive cycles (preloaded 0xA, 0xB, 0xC) -> 3 consecutive resp_valid cycles with 0xA, 0xB, 0xC in order.
REQ-033 Write behind a read: read 0x0020 (holding 0x1111), then write 0x2222 to 0x0020 the next cycle -> response 0x1111; a later read returns 0x2222.
REQ-034 Odd address and wrap: read 0x0021 -> resp_addr=0x0020. With MEM_WORDS_LOG2=4, a write to 0x0020 is visible at 0x0000.
REQ-035 Reset mid-flight: assert rst 2 cycles after a read is accepted -> no resp_valid is ever produced, and req_ready=1 the cycle after rst drops.
REQ-036 Burst (MEM_RESP_BURST_EN defined): burst read at 0x0045 (preloaded 1, 2, 3, 4 at 0x40..0x46) -> beats 1, 2, 3, 4 on cycles +4..+7 with resp_addr 0x40..0x46, and req_ready low for cycles +1..+3.
